// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes; signs are fixed up on the way out.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes honoured here
// CALC  | one iteration per cycle, counter runs 0..31
// FIN   | sign fix-up, HI/LO written, done pulsed
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               div_geq;
    logic [WIDTH-1:0]   div_diff;
    logic [AW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_signed = ~op[0];
        sign_a    = is_signed & srca[WIDTH-1];
        sign_b    = is_signed & srcb[WIDTH-1];
        mag_a     = sign_a ? (~srca + 1'b1) : srca;
        mag_b     = sign_b ? (~srcb + 1'b1) : srcb;

        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        // The partial remainder is always below the divisor, so the low WIDTH bits of the difference suffice.
        rem_sh   = acc_q[AW-1:WIDTH-1];
        div_geq  = rem_sh >= {1'b0, opb_q};
        div_diff = rem_sh[WIDTH-1:0] - opb_q;

        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? (~acc_q[AW-1:WIDTH] + 1'b1) : acc_q[AW-1:WIDTH];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        srca_d    = srca_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    srca_d    = srca;
                    opb_d     = op[1] ? mag_b : mag_a;
                    acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end else begin
                    if (mthi) hi_d = srca;
                    if (mtlo) lo_d = srca;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (div_geq) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
                    else         acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) state_d = FIN;
            end
            FIN: begin
                if (is_div_q) begin
                    if (opb_q == '0) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = srca_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            srca_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            srca_q    <= srca_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {HI,LO} queued at issue, compared when done pulses.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb, q, r;
        logic [63:0] res;
        sa = a; sb = b; sa64 = sa; sb64 = sb;
        case (o)
            2'b00: res = sa64 * sb64;
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r, q};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic wait_done(input string tag, input bit disturb);
        logic [31:0] hi0, lo0;
        logic [63:0] exp;
        int n;
        bit got, hold_ok, busy_ok;
        hi0 = hi; lo0 = lo;
        n = 0; got = 0; hold_ok = 1; busy_ok = 1;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
            else begin
                if (hi !== hi0 || lo !== lo0) hold_ok = 0;
                if (busy !== 1'b1) busy_ok = 0;
                if (n == 1) begin
                    srca = $urandom;
                    srcb = $urandom;
                end
                if (disturb && n == 9) begin
                    start = 1; mthi = 1; mtlo = 1; op = 2'b11;
                    srca = 32'hDEAD_BEEF; srcb = 32'h0000_0003;
                end
                if (disturb && n == 10) begin
                    start = 0; mthi = 0; mtlo = 0;
                end
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, exp);
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb);
        @(posedge clk); #1;
        op = o; srca = a; srcb = b; start = 1;
        exp_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        start = 0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        wait_done(tag, disturb);
    endtask

    initial begin
        reset = 1; start = 0; mthi = 0; mtlo = 0; op = 2'b00; srca = '0; srcb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
        check("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
        run_op("divu_by0", 2'b11, 32'h1234_5678, 32'd0, 0);
        check("divu_by0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op("div_by0", 2'b10, 32'h8765_4321, 32'd0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div_negneg", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb, 0);
        end

        run_op("multu_5x6_ignore", 2'b01, 32'd5, 32'd6, 1);
        check("multu_5x6_const", {hi, lo}, {32'd0, 32'd30});

        mtlo = 1; srca = 32'hCAFE_BABE;
        @(posedge clk); #1;
        mtlo = 0;
        check("mtlo_lo", 64'(lo), 64'hCAFE_BABE);
        check("mtlo_hi", 64'(hi), 64'd0);
        mthi = 1; srca = 32'h1357_9BDF;
        @(posedge clk); #1;
        mthi = 0;
        check("mthi_hi", 64'(hi), 64'h1357_9BDF);
        check("mthi_lo", 64'(lo), 64'hCAFE_BABE);
        mthi = 1; mtlo = 1; srca = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mthi = 0; mtlo = 0;
        check("mtboth", {hi, lo}, 64'h0BAD_F00D_0BAD_F00D);

        start = 1; mthi = 1; op = 2'b01; srca = 32'd2; srcb = 32'd3;
        exp_q.push_back(model(2'b01, 32'd2, 32'd3));
        @(posedge clk); #1;
        start = 0; mthi = 0;
        check("start_wins_hi", 64'(hi), 64'h0BAD_F00D);
        check("start_wins_busy", 64'(busy), 64'd1);
        wait_done("start_wins", 0);

        start = 1; op = 2'b11; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        run_op("post_rst", 2'b11, 32'd1000, 32'd3, 0);
        check("post_rst_const", {hi, lo}, {32'd1, 32'd333});

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
